// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: harvest FSM encoding, FIFO entry layout, oversample ratio
// Purpose: common constants and types for the UART receive/transmit control path.
// Ports: none (package).
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Harvest FSM encoding, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_CLEAR   = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  // FIFO entry layout: {enderror, errdata, byte}.
  typedef struct packed {
    logic       enderror;
    logic       errdata;
    logic [7:0] data;
  } entry_t;

  localparam int ENTRY_W      = $bits(entry_t);
  localparam int BYTE_LSB     = 0;
  localparam int BYTE_MSB     = 7;
  localparam int ERRDATA_BIT  = 8;
  localparam int ENDERROR_BIT = 9;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - host-side read/status interface of the UART receive controller
// Purpose: bundles the FIFO pop handshake and overrun status between controller and host.
// Signals: rd_valid, rd_data[9:0], fifo_count, overrun (controller -> host);
//          rd_pop, clr_ovr (host -> controller).
// Modports: master = host side, slave = controller side.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 4
);
  import uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_pop;
  logic [CW-1:0]      fifo_count;
  logic               overrun;
  logic               clr_ovr;

  modport master (
    input  rd_valid, rd_data, fifo_count, overrun,
    output rd_pop, clr_ovr
  );

  modport slave (
    output rd_valid, rd_data, fifo_count, overrun,
    input  rd_pop, clr_ovr
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous first-word-fall-through FIFO shared by the UART paths
// Purpose: circular buffer, DEPTH entries (power of two) of WIDTH bits.
// Ports: clk, rst (sync active-low); push/push_data write side; pop read side;
//        head_data (0 when empty), full, empty, count.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap at DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset; masking keeps the head at 0 whenever nothing is queued.
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: oversample divider, frame harvest FSM, frame FIFO
// Purpose: ticks uart_rx at 16x baud, collects completed frames into a FIFO and re-arms the receiver.
// Ports: clk, rst (sync active-low); en enables the divider; rx_clk_en sampling tick;
//        state_clear re-arm pulse; ready/errdata/enderror/rx_data from uart_rx;
//        rd_if (slave) host pop handshake, fifo_count, sticky overrun, clr_ovr.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV   = 27,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rx_clk_en,
  output logic                 state_clear,
  input  logic                 ready,
  input  logic                 errdata,
  input  logic                 enderror,
  input  logic [7:0]           rx_data,
  uart_rx_ctrl_if.slave        rd_if
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic [15:0]            div_cnt;
  logic [1:0]             state;
  entry_t                 cap_entry;
  logic                   push_req;
  logic                   pop_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     head_data;
  logic [$clog2(DEPTH):0] count;

  // Divider: the tick is the registered terminal-count compare, so it lands
  // DIV cycles after the counter starts from 0.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      div_cnt   <= '0;
      rx_clk_en <= 1'b0;
    end else begin
      rx_clk_en <= (div_cnt == DIV_LAST);
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Harvest FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (ready) state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_CLEAR;
        // uart_rx lets a tick win over the clear, so hold CLEAR until a tick-free cycle.
        ST_CLEAR:   if (!rx_clk_en) state <= ST_WAIT;
        ST_WAIT:    if (!ready) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign state_clear = (state == ST_CLEAR) && !rx_clk_en;

  // The FIFO write in CAPTURE is the frame latch; uart_rx holds its outputs until cleared.
  assign cap_entry = {enderror, errdata, rx_data};
  assign push_req  = (state == ST_CAPTURE);
  assign pop_ok    = rd_if.rd_pop && !fifo_empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (cap_entry),
    .pop       (rd_if.rd_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // A dropped frame wins over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_if.overrun <= 1'b0;
    end else if (push_req && fifo_full && !pop_ok) begin
      rd_if.overrun <= 1'b1;
    end else if (rd_if.clr_ovr) begin
      rd_if.overrun <= 1'b0;
    end
  end

  assign rd_if.rd_valid   = !fifo_empty;
  assign rd_if.rd_data    = head_data;
  assign rd_if.fifo_count = count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
// Purpose: directed frames against a cycle-level behavioural model plus literal expectations.
// Ports: none (top-level bench).
module tb_uart_rx_ctrl;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int EXP_TICKS [5] = '{4, 8, 12, 16, 20};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic       errdata = 1'b0;
  logic       enderror = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_clk_en;
  logic       state_clear;

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) rd_if ();

  uart_rx_ctrl #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rx_clk_en   (rx_clk_en),
    .state_clear (state_clear),
    .ready       (ready),
    .errdata     (errdata),
    .enderror    (enderror),
    .rx_data     (rx_data),
    .rd_if       (rd_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_n counts consecutive enabled cycles, a frame is tracked by
  // its age since ready rose, and the FIFO is a queue.
  int         m_n = 0;
  bit         m_tick = 1'b0;
  logic [9:0] m_q [$];
  bit         m_ovr = 1'b0;
  bit         m_busy = 1'b0;
  int         m_age = 0;
  bit         m_done = 1'b0;

  function automatic bit m_clear();
    return m_busy && (m_age >= 2) && !m_done && !m_tick;
  endfunction

  always @(posedge clk) begin
    bit pop;
    bit set;
    bit clr_now;
    if (!rst) begin
      m_n = 0; m_tick = 1'b0; m_q.delete(); m_ovr = 1'b0;
      m_busy = 1'b0; m_age = 0; m_done = 1'b0;
    end else begin
      clr_now = m_clear();
      pop = rd_if.rd_pop && (m_q.size() > 0);
      set = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (m_busy && m_age == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back({enderror, errdata, rx_data});
        else set = 1'b1;
      end
      m_ovr = set ? 1'b1 : (rd_if.clr_ovr ? 1'b0 : m_ovr);
      if (!m_busy) begin
        if (ready) begin m_busy = 1'b1; m_age = 1; m_done = 1'b0; end
      end else if (m_done && !ready) begin
        m_busy = 1'b0;
      end else begin
        if (clr_now) m_done = 1'b1;
        m_age++;
      end
      if (en) begin m_n++; m_tick = (m_n % DIV == 0); end
      else begin m_n = 0; m_tick = 1'b0; end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("rx_clk_en", rx_clk_en, m_tick);
      check("state_clear", state_clear, m_clear());
      check("rd_valid", rd_if.rd_valid, m_q.size() > 0);
      check("rd_data", rd_if.rd_data, (m_q.size() > 0) ? m_q[0] : 10'h000);
      check("fifo_count", rd_if.fifo_count, m_q.size());
      check("overrun", rd_if.overrun, m_ovr);
    end
  end

  // One frame from a uart_rx stand-in: ready held until a state_clear is seen.
  task automatic frame(input logic [7:0] b, input logic pe, input logic se,
                       input logic pop_cap, input logic clr_cap,
                       output logic [9:0] head2, output logic valid2,
                       output int clr_at, output int clr_cnt);
    ready = 1'b1; rx_data = b; errdata = pe; enderror = se;
    clr_at = -1; clr_cnt = 0; head2 = '0; valid2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin rd_if.rd_pop = pop_cap; rd_if.clr_ovr = clr_cap; end
      if (i == 2) begin
        rd_if.rd_pop = 1'b0; rd_if.clr_ovr = 1'b0;
        head2 = rd_if.rd_data; valid2 = rd_if.rd_valid;
      end
      if (state_clear) begin
        clr_cnt++;
        if (clr_at < 0) clr_at = i;
        ready = 1'b0;
      end
    end
  endtask

  task automatic pop_one(output logic [9:0] h);
    h = rd_if.rd_data;
    rd_if.rd_pop = 1'b1;
    @(negedge clk);
    rd_if.rd_pop = 1'b0;
  endtask

  initial begin
    logic [9:0] h;
    logic       v;
    int         ca;
    int         cc;
    int         tick_list [$];
    int         nt;
    int         first;

    rd_if.rd_pop = 1'b0;
    rd_if.clr_ovr = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rd_valid", rd_if.rd_valid, 0);
    check("reset fifo_count", rd_if.fifo_count, 0);
    check("reset rx_clk_en", rx_clk_en, 0);

    // Divider from reset release.
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rx_clk_en) tick_list.push_back(k);
    end
    check("tick count", tick_list.size(), 5);
    for (int j = 0; j < 5 && j < tick_list.size(); j++)
      check("tick cycle", tick_list[j], EXP_TICKS[j]);

    en = 1'b0;
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rx_clk_en) nt++;
    end
    check("ticks while disabled", nt, 0);
    en = 1'b1;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rx_clk_en && first < 0) first = k;
    end
    check("first tick after enable", first, DIV);
    en = 1'b0;
    @(negedge clk);

    // Single clean frame.
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, h, v, ca, cc);
    check("single head", h, 10'h0A5);
    check("single valid", v, 1);
    check("single clear cycle", ca, 2);
    check("single clear width", cc, 1);
    pop_one(h);
    check("after pop valid", rd_if.rd_valid, 0);
    check("after pop count", rd_if.fifo_count, 0);

    // Error flags.
    frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, h, v, ca, cc);
    check("errflags head", h, 10'h33C);
    pop_one(h);

    // Clear colliding with a tick: start the frame two cycles after a tick.
    en = 1'b1;
    first = 0;
    for (int k = 0; k < 10 && !first; k++) begin
      @(negedge clk);
      if (rx_clk_en) first = 1;
    end
    check("tick found", first, 1);
    repeat (2) @(negedge clk);
    frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, h, v, ca, cc);
    check("collision clear cycle", ca, 3);
    check("collision clear width", cc, 1);
    pop_one(h);
    check("collision data", h, 10'h096);

    // Overflow without pops.
    for (int f = 1; f <= 5; f++) begin
      frame(8'(f * 8'h11), 1'b0, 1'b0, 1'b0, 1'b0, h, v, ca, cc);
      check("ovf clear width", cc, 1);
    end
    check("ovf count", rd_if.fifo_count, 4);
    check("ovf overrun", rd_if.overrun, 1);
    pop_one(h); check("ovf pop1", h, 10'h011);
    pop_one(h); check("ovf pop2", h, 10'h022);
    pop_one(h); check("ovf pop3", h, 10'h033);
    pop_one(h); check("ovf pop4", h, 10'h044);
    check("ovf drained", rd_if.rd_valid, 0);
    rd_if.clr_ovr = 1'b1;
    @(negedge clk);
    rd_if.clr_ovr = 1'b0;
    check("clr_ovr", rd_if.overrun, 0);

    // Overflow with a pop in the 5th capture, then set beating clear.
    for (int f = 1; f <= 5; f++)
      frame(8'(f * 8'h11), 1'b0, 1'b0, (f == 5), 1'b0, h, v, ca, cc);
    check("pop-cap count", rd_if.fifo_count, 4);
    check("pop-cap overrun", rd_if.overrun, 0);
    check("pop-cap head", rd_if.rd_data, 10'h022);
    frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, h, v, ca, cc);
    check("set beats clr", rd_if.overrun, 1);
    rd_if.clr_ovr = 1'b1;
    @(negedge clk);
    rd_if.clr_ovr = 1'b0;
    check("clr_ovr again", rd_if.overrun, 0);
    for (int p = 0; p < 4; p++) pop_one(h);
    check("last popped", h, 10'h055);

    // Reset in the middle of CLEAR.
    en = 1'b0;
    @(negedge clk);
    ready = 1'b1; rx_data = 8'h77; errdata = 1'b0; enderror = 1'b0;
    repeat (2) @(negedge clk);
    check("in clear", state_clear, 1);
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("rst state_clear", state_clear, 0);
    check("rst rd_valid", rd_if.rd_valid, 0);
    check("rst rd_data", rd_if.rd_data, 0);
    check("rst fifo_count", rd_if.fifo_count, 0);
    check("rst overrun", rd_if.overrun, 0);
    rst = 1'b1;
    @(negedge clk);
    frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, h, v, ca, cc);
    check("post-rst head", h, 10'h05A);
    check("post-rst clear cycle", ca, 2);
    pop_one(h);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver (`uart_rx`). It generates the 16x oversampling enable `rx_clk_en` from the system clock. It harvests each completed frame (`rx_data` plus the `errdata`/`enderror` flags) into a small FIFO and pulses `state_clear` to re-arm the receiver. It sits between `uart_rx` and the host or bus logic, which pops frames through a valid/pop handshake.

## Interface
Parameters:
- `DIV`, 27: clk cycles per `rx_clk_en` pulse (clk / (baud×16)); legal 2..65535.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: 1 = run the divider; 0 = counter held at 0, no ticks.
- `rx_clk_en` out 1: one-cycle sampling tick to `uart_rx`.
- `state_clear` out 1: one-cycle clear pulse to `uart_rx`.
- `ready` in 1: frame-complete level from `uart_rx`; held until cleared.
- `errdata` in 1: parity error level from `uart_rx`.
- `enderror` in 1: stop-bit error level from `uart_rx`.
- `rx_data` in 8: received byte from `uart_rx`.
- `rd_valid` out 1: FIFO non-empty.
- `rd_data` out 10: head entry {enderror, errdata, byte[7:0]}, first-word-fall-through.
- `rd_pop` in 1: pop the head entry; ignored when `rd_valid`=0.
- `fifo_count` out clog2(DEPTH)+1: number of occupied entries.
- `overrun` out 1: sticky flag; a frame arrived while the FIFO was full.
- `clr_ovr` in 1: clears `overrun`.

## Operation
- Divider: `div_cnt` counts 0..DIV-1 while `en`=1 and wraps to 0. `rx_clk_en`=1 exactly in the cycle where `div_cnt`==DIV-1, registered.
- Harvest FSM, 4 states:
  - IDLE: if `ready`=1, go to CAPTURE.
  - CAPTURE: latch {enderror, errdata, rx_data}. Push the entry if the FIFO is not full, else set `overrun` and drop the frame. Go to CLEAR.
  - CLEAR: assert `state_clear` for one cycle, only if `rx_clk_en`=0 in this cycle. `uart_rx` lets a tick override the clear, so on a tick the FSM stays in CLEAR one more cycle. Then go to WAIT.
  - WAIT: stay while `ready`=1; go to IDLE when `ready`=0.
- FIFO: circular buffer with pointer wrap at DEPTH.
  - Push only from CAPTURE.
  - Pop when `rd_pop`&&`rd_valid`.
  - Push and pop in the same cycle with the FIFO full: both happen; count unchanged; no overrun.
  - Pop on empty: no effect.
- `overrun`: set has priority over `clr_ovr` in the same cycle.
- Reset (any cycle, including mid-frame or mid-CLEAR):
  - FSM returns to IDLE.
  - `div_cnt`=0, pointers=0, `fifo_count`=0.
  - All outputs 0: `rx_clk_en`, `state_clear`, `rd_valid`, `overrun`, `rd_data`.
  - FIFO storage contents are don't-care.

## Timing
- `ready` first high in cycle N (IDLE):
  - CAPTURE in N+1; entry visible (`rd_valid`=1) in N+2.
  - `state_clear` high in N+2, or later if delayed by a tick.
  - `ready` low in N+3; IDLE in N+4.
- Minimum IDLE→IDLE harvest is 4 cycles, far shorter than one bit time (16×DIV cycles). No frame is lost through FSM latency.
- Pop: `fifo_count` decrements and `rd_data` advances at the next edge.
- After reset release with `en`=1, the first `rx_clk_en` pulse follows DIV cycles later.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/CAPTURE/CLEAR/WAIT, 2-bit).
  - Entry layout constants: byte [7:0], errdata bit 8, enderror bit 9.
  - Oversample constant 16.
- Sub-module `uart_sync_fifo`: DEPTH/WIDTH parameters, push/pop/full/empty/count. This is reused later by the TX path.
- The divider and FSM stay in the top module.

## Test plan
- Divider: DIV=4, `en`=1 for 20 cycles → `rx_clk_en` pulses at cycles 4, 8, 12, 16, 20 after reset release; `en`=0 → no pulses, counter frozen at 0.
- Single frame: `ready`=1 with `rx_data`=0xA5, flags 0 → `rd_data`=0x0A5 and `rd_valid`=1 at N+2; one `state_clear` pulse; pop → `rd_valid`=0, `fifo_count`=0.
- Error flags: `errdata`=1, `enderror`=1, byte 0x3C → `rd_data`=0x33C.
- Clear/tick collision: force `rx_clk_en` in the CLEAR cycle → `state_clear` is deferred one cycle and stays exactly one cycle wide.
- Overflow: DEPTH=4, 5 frames with no pops → `fifo_count`=4, `overrun`=1, 5th byte dropped. Repeat with a pop in the 5th CAPTURE cycle → `fifo_count`=4, `overrun`=0. `clr_ovr` → 0.
- Reset mid-CLEAR: `rst`=0 → next cycle all outputs 0, FSM IDLE. A subsequent frame harvests normally.
